sine_lut: RTL and testbench

SINE_LUT -- requirements
Module: sine_lut

---
 rtl/sine_lut.sv | 106 ++++++++++
 tb/tb_sine_lut.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sine_lut.sv
// sine_lut: registered sine/cosine generator driven by a quarter-wave table.
// Define SINE_LUT_SIGNED_EN for two's-complement outputs instead of offset binary.
module sine_lut #(
  parameter int I_WIDTH = 8,
  parameter int O_WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [I_WIDTH-1:0] i_phase,
  output logic [O_WIDTH-1:0] o_sin,
  output logic [O_WIDTH-1:0] o_cos
);

  localparam int AW = O_WIDTH - 1;
  localparam int QN = 2 ** (I_WIDTH - 2);
  localparam real PI = 3.14159265358979323846;

  localparam logic [O_WIDTH-1:0] MID     = {1'b1, {(O_WIDTH-1){1'b0}}};
  localparam logic [O_WIDTH-1:0] AMP     = {1'b0, {(O_WIDTH-1){1'b1}}};
  localparam logic [I_WIDTH-2:0] QN_IDX  = {1'b1, {(I_WIDTH-2){1'b0}}};
  localparam logic [I_WIDTH-1:0] QTR_PH  = {2'b01, {(I_WIDTH-2){1'b0}}};

`ifdef SINE_LUT_SIGNED_EN
  localparam logic [O_WIDTH-1:0] RST_SIN = {O_WIDTH{1'b0}};
  localparam logic [O_WIDTH-1:0] RST_COS = AMP;
`else
  localparam logic [O_WIDTH-1:0] RST_SIN = MID;
  localparam logic [O_WIDTH-1:0] RST_COS = MID + AMP;
`endif

  // One quarter-wave magnitude, rounded half away from zero (argument is never negative).
  function automatic logic [AW-1:0] quarter_entry(input int q);
    real theta;
    real amp;
    theta = 2.0 * PI * real'(q) / real'(4 * QN);
    amp   = real'((2 ** AW) - 1);
    return AW'($rtoi(amp * $sin(theta) + 0.5));
  endfunction

  logic [AW-1:0] quarter_s [0:QN];

  for (genvar g = 0; g <= QN; g++) begin : g_quarter
    assign quarter_s[g] = quarter_entry(g);
  end

  // Quadrant 1 and 3 mirror the address about N/4; the lower half circle negates.
  function automatic logic [O_WIDTH-1:0] wave(input logic [I_WIDTH-1:0] ph);
    logic [I_WIDTH-2:0] idx;
    logic [AW-1:0]      mag;
    logic [O_WIDTH-1:0] res;
    if (ph[I_WIDTH-2]) begin
      idx = QN_IDX - {1'b0, ph[I_WIDTH-3:0]};
    end else begin
      idx = {1'b0, ph[I_WIDTH-3:0]};
    end
    mag = quarter_s[idx];
`ifdef SINE_LUT_SIGNED_EN
    if (ph[I_WIDTH-1]) begin
      res = {O_WIDTH{1'b0}} - {1'b0, mag};
    end else begin
      res = {1'b0, mag};
    end
`else
    if (ph[I_WIDTH-1]) begin
      res = MID - {1'b0, mag};
    end else begin
      res = MID + {1'b0, mag};
    end
`endif
    return res;
  endfunction

  logic [O_WIDTH-1:0] sin_d, sin_q;
  logic [O_WIDTH-1:0] cos_d, cos_q;
  logic [I_WIDTH-1:0] cos_ph_s;

  // Next-state selection: new lookup when enabled, otherwise hold.
  always_comb begin
    cos_ph_s = i_phase + QTR_PH;
    sin_d    = sin_q;
    cos_d    = cos_q;
    if (i_en) begin
      sin_d = wave(i_phase);
      cos_d = wave(cos_ph_s);
    end else begin
      sin_d = sin_q;
      cos_d = cos_q;
    end
  end

  // Single output register stage; reset forces the phase-0 sample.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sin_q <= RST_SIN;
      cos_q <= RST_COS;
    end else begin
      sin_q <= sin_d;
      cos_q <= cos_d;
    end
  end

  assign o_sin = sin_q;
  assign o_cos = cos_q;

endmodule

// File: tb/tb_sine_lut.sv
// tb_sine_lut: table-driven and randomized checks of sine_lut (8-bit phase, 8-bit offset-binary output).
module tb_sine_lut;

  localparam real PI = 3.14159265358979323846;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] phase;
  logic [7:0] o_sin;
  logic [7:0] o_cos;

  int checks = 0;
  int errors = 0;

  sine_lut #(.I_WIDTH(8), .O_WIDTH(8)) dut (
    .i_clk  (clk),
    .i_rst  (rst_n),
    .i_en   (en),
    .i_phase(phase),
    .o_sin  (o_sin),
    .o_cos  (o_cos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else return -$rtoi(-x + 0.5);
  endfunction

  function automatic int ref_sin(input int p);
    return 128 + rnd(127.0 * $sin(2.0 * PI * real'(p) / 256.0));
  endfunction

  function automatic int ref_cos(input int p);
    return 128 + rnd(127.0 * $cos(2.0 * PI * real'(p) / 256.0));
  endfunction

  task automatic check(input string name, input logic [15:0] act, input int exp);
    checks++;
    if ($isunknown(act) || int'(act) != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_pair(input string name, input int es, input int ec);
    check({name, " sin"}, {8'h00, o_sin}, es);
    check({name, " cos"}, {8'h00, o_cos}, ec);
  endtask

  task automatic apply(input int p, input logic e);
    @(negedge clk);
    phase = 8'(p);
    en    = e;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int p;
    int es;
    int ec;
  } vec_t;

  vec_t vecs[9];
  int   sin_cap[256];
  int   exp_s, exp_c;

  initial begin
    vecs[0] = '{0,   128, 255};
    vecs[1] = '{16,  177, 245};
    vecs[2] = '{32,  218, 218};
    vecs[3] = '{64,  255, 128};
    vecs[4] = '{128, 128, 1};
    vecs[5] = '{192, 1,   128};
    vecs[6] = '{255, 125, 255};
    vecs[7] = '{0,   128, 255};
    vecs[8] = '{1,   131, 255};

    rst_n = 1'b0;
    en    = 1'b1;
    phase = 8'd77;

    // Reset held across clock edges
    repeat (3) @(posedge clk);
    #1;
    check_pair("reset hold", 128, 255);

    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors including the 255 -> 0 -> 1 wrap
    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].p, 1'b1);
      check_pair($sformatf("vec p=%0d", vecs[i].p), vecs[i].es, vecs[i].ec);
    end

    // Enable low holds the last sample
    apply(64, 1'b1);
    check_pair("hold load", 255, 128);
    for (int i = 0; i < 5; i++) begin
      apply(0, 1'b0);
      check_pair($sformatf("hold cyc%0d", i), 255, 128);
    end
    apply(0, 1'b1);
    check_pair("hold release", 128, 255);

    // Asynchronous reset between edges mid-stream
    apply(100, 1'b1);
    check_pair("pre reset", ref_sin(100), ref_cos(100));
    #2;
    rst_n = 1'b0;
    #1;
    check_pair("async reset", 128, 255);
    @(posedge clk);
    #1;
    check_pair("reset over edge", 128, 255);
    @(negedge clk);
    rst_n = 1'b1;
    apply(37, 1'b1);
    check_pair("first after reset", ref_sin(37), ref_cos(37));

    // Full sweep against the reference model
    for (int p = 0; p < 256; p++) begin
      apply(p, 1'b1);
      check_pair($sformatf("sweep p=%0d", p), ref_sin(p), ref_cos(p));
      sin_cap[p] = int'(o_sin);
    end
    for (int p = 0; p < 128; p++) begin
      check($sformatf("antisym p=%0d", p), 16'(sin_cap[p] + sin_cap[p + 128]), 256);
    end

    // Random phase and enable with a holding model
    apply(0, 1'b1);
    exp_s = 128;
    exp_c = 255;
    check_pair("rand start", exp_s, exp_c);
    for (int i = 0; i < 300; i++) begin
      int   p;
      logic e;
      p = int'($urandom_range(255, 0));
      e = ($urandom_range(3, 0) != 0);
      apply(p, e);
      if (e) begin
        exp_s = ref_sin(p);
        exp_c = ref_cos(p);
      end
      check_pair($sformatf("rand %0d p=%0d en=%0b", i, p, e), exp_s, exp_c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
